// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver
// Purpose  : Four-digit seven-segment driver for a calculator. A load strobe
//            captures an unsigned 14-bit magnitude plus sign and error flags.
//            An iterative shift-and-add-3 converter turns the magnitude into
//            BCD, one bit per cycle. The formatted digits (error text,
//            leading-zero blanking, minus sign) are then committed to the
//            display registers. The display is scanned continuously by an
//            externally generated refresh index.
// Ports    : clk               - system clock, rising edge
//            rst_n             - asynchronous active-low reset
//            i_refresh_counter - digit-scan index (0 = rightmost digit)
//            i_load            - one-cycle strobe, new value to display
//            i_value_in        - unsigned magnitude, sampled with i_load
//            i_negative_in     - sign flag, sampled with i_load
//            i_error_in        - error flag, sampled with i_load
//            o_busy            - conversion in progress
//            o_an              - digit enables, active-low, one-hot-low
//            o_seg             - segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_driver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_refresh_counter,
    input  logic        i_load,
    input  logic [13:0] i_value_in,
    input  logic        i_negative_in,
    input  logic        i_error_in,
    output logic        o_busy,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] c_SEG_MINUS = 7'b0111111;
    localparam logic [6:0] c_SEG_E     = 7'b0000110;
    localparam logic [6:0] c_SEG_R     = 7'b0101111;
    localparam logic [3:0] c_LAST_SHIFT = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] f_numeral(input logic [3:0] i_d);
        case (i_d)
            4'd0:    f_numeral = 7'b1000000;
            4'd1:    f_numeral = 7'b1111001;
            4'd2:    f_numeral = 7'b0100100;
            4'd3:    f_numeral = 7'b0110000;
            4'd4:    f_numeral = 7'b0011001;
            4'd5:    f_numeral = 7'b0010010;
            4'd6:    f_numeral = 7'b0000010;
            4'd7:    f_numeral = 7'b1111000;
            4'd8:    f_numeral = 7'b0000000;
            4'd9:    f_numeral = 7'b0010000;
            default: f_numeral = c_SEG_BLANK;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Scan index: two-flop synchronizer, index only follows once both stages
    // agree so a single-cycle glitch never reaches the anodes.
    // ------------------------------------------------------------------------
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_idx;
    logic       r_active;
    logic [1:0] w_idx;

    assign w_idx = (r_sync1 == r_sync2) ? r_sync2 : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 2'd0;
            r_sync2  <= 2'd0;
            r_idx    <= 2'd0;
            r_active <= 1'b0;
        end else begin
            r_sync1  <= i_refresh_counter;
            r_sync2  <= r_sync1;
            r_idx    <= w_idx;
            r_active <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [13:0]     r_bin;
    logic [15:0]     r_bcd;
    logic [3:0]      r_cnt;
    logic [13:0]     r_val;
    logic            r_neg;
    logic            r_err;
    logic            r_busy;
    logic [3:0][6:0] r_dig;

    // Add-3 correction on every BCD nibble that is 5 or more before a shift.
    logic [15:0] w_bcd_adj;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          (r_bcd[gi*4 +: 4] + 4'd3) :
                                           r_bcd[gi*4 +: 4];
        end
    endgenerate

    // Formatting of the finished BCD result into segment patterns.
    logic            w_is_err;
    logic [1:0]      w_msd;
    logic [3:0][6:0] w_disp;

    always_comb begin
        w_is_err = r_err || (r_val > 14'd9999) || (r_neg && (r_val > 14'd999));
        if (r_bcd[15:12] != 4'd0)      w_msd = 2'd3;
        else if (r_bcd[11:8] != 4'd0)  w_msd = 2'd2;
        else if (r_bcd[7:4] != 4'd0)   w_msd = 2'd1;
        else                           w_msd = 2'd0;

        w_disp = {4{c_SEG_BLANK}};
        if (w_is_err) begin
            w_disp[3] = c_SEG_BLANK;
            w_disp[2] = c_SEG_E;
            w_disp[1] = c_SEG_R;
            w_disp[0] = c_SEG_R;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (2'(k) <= w_msd) begin
                    w_disp[k] = f_numeral(r_bcd[k*4 +: 4]);
                end else if (r_neg && (r_val != 14'd0) &&
                             (3'(k) == ({1'b0, w_msd} + 3'd1))) begin
                    // -0 has no sign; the minus sits just left of the MSD.
                    w_disp[k] = c_SEG_MINUS;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bin   <= 14'd0;
            r_bcd   <= 16'd0;
            r_cnt   <= 4'd0;
            r_val   <= 14'd0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_dig   <= {4{c_SEG_BLANK}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_bin   <= i_value_in;
                        r_val   <= i_value_in;
                        r_neg   <= i_negative_in;
                        r_err   <= i_error_in;
                        r_bcd   <= 16'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[14:0], r_bin[13]};
                    r_bin <= {r_bin[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_SHIFT) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_dig   <= w_disp;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: anodes and segments follow the scan index; dark in reset.
    // ------------------------------------------------------------------------
    always_comb begin
        o_an  = 4'b1111;
        o_seg = c_SEG_BLANK;
        if (r_active) begin
            case (w_idx)
                2'd0:    o_an = 4'b1110;
                2'd1:    o_an = 4'b1101;
                2'd2:    o_an = 4'b1011;
                default: o_an = 4'b0111;
            endcase
            o_seg = r_dig[w_idx];
        end
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 refresh_counter  input  2  digit-scan index from count_refresh (0 = rightmost digit).
REQ-004 load  input  1  one-cycle strobe; new value to display.
REQ-005 value_in  input  14  unsigned magnitude, sampled with load.
REQ-006 negative_in  input  1  sign flag, sampled with load.
REQ-007 error_in  input  1  calculator error flag, sampled with load.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 an  output  4  digit enables, active-low, one-hot-low.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 The refresh_counter input SHALL pass through a 2-flop synchronizer; the scan index SHALL update only when both synchronized samples agree.
REQ-012 an SHALL drive bit k low and all others high, where k = current scan index; seg SHALL show the pattern of digit k.
REQ-013 FSM states SHALL be IDLE, SHIFT and COMMIT; IDLE->SHIFT on load, SHIFT->COMMIT after 14 shift cycles, COMMIT->IDLE after 1 cycle.
REQ-014 Conversion SHALL use iterative shift-and-add-3, one bit per cycle, MSB first, with 16-bit BCD scratch.
REQ-015 With load sampled at edge N, busy SHALL be high after edges N..N+14; displayed digits SHALL update at edge N+15, when busy returns low.
REQ-016 A load while busy SHALL be ignored; inputs captured at the accepted load SHALL be unaffected.
REQ-017 Displayed digits SHALL hold their previous values throughout a conversion.
REQ-018 The error display SHALL be used if error_in = 1, if value_in > 9999, or if negative_in = 1 and value_in > 999.
REQ-019 Error display: digit3 blank, digit2 'E' 0000110, digit1 'r' 0101111, digit0 'r' 0101111.
REQ-020 Leading zeros SHALL be blanked (1111111); digit0 SHALL always show a numeral, so value 0 shows '0'.
REQ-021 When negative, '-' (0111111) SHALL occupy the digit immediately left of the most significant shown digit; -0 SHALL display as '0', with no sign.
REQ-022 Numeral encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 Scanning SHALL continue in all states, using the committed digit registers only.

Reset
REQ-024 While rst_n = 0: FSM = IDLE, busy = 0, an = 1111, seg = 1111111, all digit registers blank, synchronizer flops = 0.
REQ-025 After reset release: scanning resumes with all digits blank until the first COMMIT.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion; no partial digits shall be committed.

Verification
REQ-027 Reset: assert rst_n = 0 -> an = 1111, seg = 1111111, busy = 0; release and scan 0..3 -> seg = 1111111 for every digit.
REQ-028 Load 1234, positive -> busy high for exactly 15 cycles; digits 0..3 = 0011001, 0110000, 0100100, 1111001.
REQ-029 Load 7, negative -> digit0 = 1111000, digit1 = 0111111, digits 2 and 3 = 1111111; load 0 -> digit0 = 1000000, others blank.
REQ-030 Load 10000; separately load 1000 negative; separately load error_in = 1 -> each shows the Err pattern of REQ-019.
REQ-031 Load 42, then load 99 while busy -> 99 ignored, display 42; reset at cycle 5 of a conversion -> blank display, busy = 0.
REQ-032 Change refresh_counter 0->1 -> an changes from 1110 to 1101 exactly 2 cycles after the change; a one-cycle glitch on refresh_counter -> no change on an.
